bidcounter_sweep_ctrl: RTL and testbench

BIDCOUNTER_SWEEP_CTRL -- requirements
Module: bidcounter_sweep_ctrl

---
 rtl/bidcounter_sweep_ctrl_pkg.sv | 14 +
 rtl/bidcounter_sweep_ctrl_if.sv | 32 +++
 rtl/bidcounter_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_bidcounter_sweep_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bidcounter_sweep_ctrl_pkg.sv
// Shared definitions for the bidirectional-counter sweep controller:
// FSM state encoding and the default counter/bound width.
package bidcounter_sweep_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/bidcounter_sweep_ctrl_if.sv
// Bundle between the sweep controller and its integration: run requests,
// sweep bounds, counter feedback and the controller's registered outputs.
interface bidcounter_sweep_ctrl_if
  import bidcounter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] n_sweeps;
  logic [WIDTH-1:0] count;
  logic             ctrl;
  logic             cnt_reset;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] sweeps_done;

  modport master (
    output start, abort, lo, hi, n_sweeps, count,
    input  ctrl, cnt_reset, busy, done, err, sweeps_done
  );

  modport slave (
    input  start, abort, lo, hi, n_sweeps, count,
    output ctrl, cnt_reset, busy, done, err, sweeps_done
  );

endinterface

// File: rtl/bidcounter_sweep_ctrl.sv
// Drives an external up/down counter back and forth between lo and hi for a
// requested number of sweeps, turning one count early so it peaks/troughs exactly.
module bidcounter_sweep_ctrl
  import bidcounter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter bit UP_LEVEL = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  bidcounter_sweep_ctrl_if.slave bus
);

  localparam logic DOWN_LEVEL = ~UP_LEVEL;

  sweep_state_t     state_q, state_n;
  logic [WIDTH-1:0] lo_q, lo_n;
  logic [WIDTH-1:0] hi_q, hi_n;
  logic [WIDTH-1:0] n_q, n_n;
  logic [WIDTH-1:0] sweeps_q, sweeps_n;
  logic [WIDTH-1:0] sweeps_inc;
  logic [WIDTH-1:0] hi_m1;
  logic [WIDTH-1:0] lo_p1;
  logic             ctrl_q, ctrl_n;
  logic             cnt_reset_q, cnt_reset_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;

  // The counter moves on the same edge the direction changes, so turning
  // is decided one count before the bound is reached.
  assign hi_m1      = hi_q - WIDTH'(1);
  assign lo_p1      = lo_q + WIDTH'(1);
  assign sweeps_inc = sweeps_q + WIDTH'(1);

  always_comb begin
    state_n     = state_q;
    lo_n        = lo_q;
    hi_n        = hi_q;
    n_n         = n_q;
    sweeps_n    = sweeps_q;
    ctrl_n      = UP_LEVEL;
    cnt_reset_n = 1'b1;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ((bus.lo < bus.hi) && (bus.n_sweeps != '0)) begin
            state_n     = UP;
            lo_n        = bus.lo;
            hi_n        = bus.hi;
            n_n         = bus.n_sweeps;
            sweeps_n    = '0;
            cnt_reset_n = 1'b0;
            busy_n      = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      UP: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else begin
          cnt_reset_n = 1'b0;
          busy_n      = 1'b1;
          if (bus.count == hi_m1) begin
            state_n = DOWN;
            ctrl_n  = DOWN_LEVEL;
          end
        end
      end

      DOWN: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (bus.count == lo_p1) begin
          sweeps_n = sweeps_inc;
          if (sweeps_inc == n_q) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n     = UP;
            cnt_reset_n = 1'b0;
            busy_n      = 1'b1;
          end
        end else begin
          ctrl_n      = DOWN_LEVEL;
          cnt_reset_n = 1'b0;
          busy_n      = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      n_q         <= '0;
      sweeps_q    <= '0;
      ctrl_q      <= UP_LEVEL;
      cnt_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      lo_q        <= lo_n;
      hi_q        <= hi_n;
      n_q         <= n_n;
      sweeps_q    <= sweeps_n;
      ctrl_q      <= ctrl_n;
      cnt_reset_q <= cnt_reset_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      err_q       <= err_n;
    end
  end

  assign bus.ctrl        = ctrl_q;
  assign bus.cnt_reset   = cnt_reset_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.sweeps_done = sweeps_q;

endmodule

// File: tb/tb_bidcounter_sweep_ctrl.sv
// Bench for the sweep controller closed-loop with a simple bidirectional
// counter model; directed scenarios with hand-derived count sequences.
module tb_bidcounter_sweep_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] cnt;
  int               checks = 0;
  int               errors = 0;
  int               seen[$];
  bit               got_done;

  bidcounter_sweep_ctrl_if #(.WIDTH(WIDTH)) bus ();

  bidcounter_sweep_ctrl #(
    .WIDTH   (WIDTH),
    .UP_LEVEL(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Controlled counter: clears on cnt_reset, otherwise steps +/-1 with wrap.
  always_ff @(posedge clk) begin
    if (reset || bus.cnt_reset) cnt <= '0;
    else if (bus.ctrl)          cnt <= cnt + 1'b1;
    else                        cnt <= cnt - 1'b1;
  end

  assign bus.count = cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h,
                           input logic [WIDTH-1:0] n);
    bus.lo       = l;
    bus.hi       = h;
    bus.n_sweeps = n;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Records count every cycle of a run up to and including the done cycle.
  task automatic capture(input int budget);
    seen.delete();
    got_done = 1'b0;
    seen.push_back(int'(bus.count));
    for (int i = 0; i < budget && !got_done; i++) begin
      tick();
      seen.push_back(int'(bus.count));
      if (bus.done) got_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.lo       = '0;
    bus.hi       = '0;
    bus.n_sweeps = '0;
    tick();
    tick();
    checks++;
    if ({bus.ctrl, bus.cnt_reset, bus.busy, bus.done, bus.err} !== 5'b11000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 11000",
               {bus.ctrl, bus.cnt_reset, bus.busy, bus.done, bus.err});
    end
    checks++;
    if (bus.sweeps_done !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_sweeps_done: got %0d expected 0", bus.sweeps_done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: count %0d busy %b expected 0 0", bus.count, bus.busy);
    end
  endtask

  task automatic test_single_sweep();
    int exp[$];
    exp = '{0, 1, 2, 3, 4, 5, 4, 3, 2};
    start_run(4'd2, 4'd5, 4'd1);
    bus.lo       = 4'd0;
    bus.hi       = 4'd15;
    bus.n_sweeps = 4'd7;
    checks++;
    if (bus.busy !== 1'b1 || bus.cnt_reset !== 1'b0 || bus.ctrl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_accept: busy %b cnt_reset %b ctrl %b expected 1 0 1",
               bus.busy, bus.cnt_reset, bus.ctrl);
    end
    capture(40);
    checks++;
    if (!got_done) begin
      errors++;
      $display("[TB] FAIL single_done_timeout: done not seen");
    end
    checks++;
    if (seen.size() != exp.size()) begin
      errors++;
      $display("[TB] FAIL single_len: got %0d values expected %0d", seen.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL single_count[%0d]: got %0d expected %0d", i, seen[i], exp[i]);
      end
    end
    checks++;
    if (bus.sweeps_done !== 4'd1) begin
      errors++;
      $display("[TB] FAIL single_sweeps_done: got %0d expected 1", bus.sweeps_done);
    end
    tick();
    checks++;
    if (bus.count !== 4'd0 || {bus.done, bus.busy, bus.cnt_reset} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL single_return: count %0d done/busy/cnt_reset %b expected 0 001",
               bus.count, {bus.done, bus.busy, bus.cnt_reset});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.sweeps_done !== 4'd1) begin
        errors++;
        $display("[TB] FAIL single_after: done %b sweeps_done %0d expected 0 1",
                 bus.done, bus.sweeps_done);
      end
    end
  endtask

  task automatic test_full_range();
    int exp[$];
    for (int s = 0; s < 2; s++) begin
      for (int v = (s == 0) ? 0 : 1; v <= 15; v++) exp.push_back(v);
      for (int v = 14; v >= 0; v--) exp.push_back(v);
    end
    start_run(4'd0, 4'd15, 4'd2);
    capture(100);
    checks++;
    if (!got_done) begin
      errors++;
      $display("[TB] FAIL full_done_timeout: done not seen");
    end
    checks++;
    if (seen.size() != exp.size()) begin
      errors++;
      $display("[TB] FAIL full_len: got %0d values expected %0d", seen.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL full_count[%0d]: got %0d expected %0d", i, seen[i], exp[i]);
      end
    end
    checks++;
    if (bus.sweeps_done !== 4'd2) begin
      errors++;
      $display("[TB] FAIL full_sweeps_done: got %0d expected 2", bus.sweeps_done);
    end
    tick();
  endtask

  task automatic test_tight();
    int exp[$];
    exp = '{0, 1, 2, 1, 2, 1, 2, 1};
    start_run(4'd1, 4'd2, 4'd3);
    capture(30);
    checks++;
    if (!got_done) begin
      errors++;
      $display("[TB] FAIL tight_done_timeout: done not seen");
    end
    checks++;
    if (seen.size() != exp.size()) begin
      errors++;
      $display("[TB] FAIL tight_len: got %0d values expected %0d", seen.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL tight_count[%0d]: got %0d expected %0d", i, seen[i], exp[i]);
      end
    end
    checks++;
    if (bus.sweeps_done !== 4'd3) begin
      errors++;
      $display("[TB] FAIL tight_sweeps_done: got %0d expected 3", bus.sweeps_done);
    end
    tick();
  endtask

  task automatic test_rejected_starts();
    logic [WIDTH-1:0] los[3];
    logic [WIDTH-1:0] his[3];
    logic [WIDTH-1:0] ns[3];
    los = '{4'd5, 4'd3, 4'd1};
    his = '{4'd5, 4'd2, 4'd4};
    ns  = '{4'd1, 4'd1, 4'd0};
    for (int k = 0; k < 3; k++) begin
      start_run(los[k], his[k], ns[k]);
      checks++;
      if ({bus.err, bus.busy, bus.cnt_reset} !== 3'b101 || bus.count !== 4'd0) begin
        errors++;
        $display("[TB] FAIL reject%0d_pulse: err/busy/cnt_reset %b count %0d expected 101 0",
                 k, {bus.err, bus.busy, bus.cnt_reset}, bus.count);
      end
      tick();
      checks++;
      if ({bus.err, bus.busy, bus.cnt_reset} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL reject%0d_after: err/busy/cnt_reset %b expected 001",
                 k, {bus.err, bus.busy, bus.cnt_reset});
      end
    end
    checks++;
    if (bus.sweeps_done !== 4'd3) begin
      errors++;
      $display("[TB] FAIL reject_sweeps_hold: got %0d expected 3", bus.sweeps_done);
    end
  endtask

  task automatic test_abort();
    int exp[$];
    exp = '{0, 1, 2, 3, 2, 1};
    start_run(4'd1, 4'd9, 4'd1);
    for (int i = 0; i < 20 && bus.count != 4'd4; i++) tick();
    checks++;
    if (bus.count !== 4'd4 || bus.ctrl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_reach4: count %0d ctrl %b expected 4 1", bus.count, bus.ctrl);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.cnt_reset, bus.done, bus.ctrl} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL abort_idle: busy/cnt_reset/done/ctrl %b expected 0101",
               {bus.busy, bus.cnt_reset, bus.done, bus.ctrl});
    end
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_cleared: count %0d done %b expected 0 0", bus.count, bus.done);
    end
    start_run(4'd1, 4'd3, 4'd1);
    checks++;
    if (bus.busy !== 1'b1 || bus.sweeps_done !== 4'd0) begin
      errors++;
      $display("[TB] FAIL abort_restart: busy %b sweeps_done %0d expected 1 0",
               bus.busy, bus.sweeps_done);
    end
    capture(20);
    checks++;
    if (!got_done || seen.size() != exp.size()) begin
      errors++;
      $display("[TB] FAIL abort_rerun: done %b len %0d expected 1 %0d",
               got_done, seen.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL abort_rerun_count[%0d]: got %0d expected %0d", i, seen[i], exp[i]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_down();
    bus.lo       = 4'd2;
    bus.hi       = 4'd6;
    bus.n_sweeps = 4'd1;
    bus.start    = 1'b1;
    tick();
    for (int i = 0; i < 20 && bus.ctrl != 1'b0; i++) tick();
    checks++;
    if (bus.ctrl !== 1'b0 || bus.count !== 4'd6) begin
      errors++;
      $display("[TB] FAIL middown_peak: ctrl %b count %0d expected 0 6", bus.ctrl, bus.count);
    end
    tick();
    checks++;
    if ({bus.busy, bus.err, bus.ctrl} !== 3'b100 || bus.count !== 4'd5) begin
      errors++;
      $display("[TB] FAIL middown_start_ignored: busy/err/ctrl %b count %0d expected 100 5",
               {bus.busy, bus.err, bus.ctrl}, bus.count);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.ctrl, bus.cnt_reset, bus.busy, bus.done, bus.err} !== 5'b11000 ||
        bus.sweeps_done !== 4'd0) begin
      errors++;
      $display("[TB] FAIL middown_reset: outputs %b sweeps_done %0d expected 11000 0",
               {bus.ctrl, bus.cnt_reset, bus.busy, bus.done, bus.err}, bus.sweeps_done);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.count !== 4'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL middown_after: count %0d done %b busy %b expected 0 0 0",
                 bus.count, bus.done, bus.busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_full_range();
    test_tight();
    test_rejected_starts();
    test_abort();
    test_reset_mid_down();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
